// File: rtl/piano_voice_alloc.sv
// Polyphonic voice allocator: assigns key presses to a small pool of tone voices.
// Build option PIANO_VOICE_STEAL_EN: steal the oldest voice when full (default: drop the press).
module piano_voice_alloc #(
  parameter int N_KEYS   = 12,
  parameter int N_VOICES = 4,
  parameter int NOTE_W   = 4,
  parameter int AGE_W    = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [N_KEYS-1:0]            keys,
  input  logic [2:0]                   octave,
  output logic [N_VOICES-1:0]          voice_gate,
  output logic [N_VOICES*NOTE_W-1:0]   voice_note,
  output logic [N_VOICES*3-1:0]        voice_octave,
  output logic [N_VOICES-1:0]          voice_new,
  output logic                         full,
  output logic [7:0]                   evt_cnt
);

  logic [N_KEYS-1:0]   keys_q;
  logic [N_KEYS-1:0]   pend;
  logic [N_KEYS-1:0]   rise;
  logic [N_KEYS-1:0]   fall;
  logic [N_KEYS-1:0]   cand;
  logic [N_KEYS-1:0]   svc_oh;
  logic [NOTE_W-1:0]   svc_key;
  logic                svc_valid;
  logic [N_VOICES-1:0] free_oh;
  logic                free_valid;
  logic [N_VOICES-1:0] tgt_oh;
  logic [N_VOICES-1:0] rel;
  logic [N_VOICES-1:0] gate_nxt;
  logic                alloc;
  logic                evt;

`ifdef PIANO_VOICE_STEAL_EN
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  logic [AGE_W-1:0]    age [N_VOICES];
  logic [AGE_W-1:0]    best_age;
  logic [N_VOICES-1:0] victim_oh;
`endif

  always_comb begin
    rise = keys & ~keys_q;
    fall = ~keys & keys_q;
    // A key falling this cycle is never serviced, even if still pending.
    cand = pend & ~fall;

    svc_valid = 1'b0;
    svc_key   = '0;
    svc_oh    = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      if (cand[k]) begin
        svc_valid = 1'b1;
        svc_key   = NOTE_W'(k);
        svc_oh    = '0;
        svc_oh[k] = 1'b1;
      end
    end

    free_valid = 1'b0;
    free_oh    = '0;
    for (int v = N_VOICES - 1; v >= 0; v--) begin
      if (!voice_gate[v]) begin
        free_valid = 1'b1;
        free_oh    = '0;
        free_oh[v] = 1'b1;
      end
    end

`ifdef PIANO_VOICE_STEAL_EN
    best_age  = age[0];
    victim_oh = '0;
    victim_oh[0] = 1'b1;
    for (int v = 1; v < N_VOICES; v++) begin
      if (age[v] > best_age) begin
        best_age     = age[v];
        victim_oh    = '0;
        victim_oh[v] = 1'b1;
      end
    end
    tgt_oh = free_valid ? free_oh : victim_oh;
    alloc  = svc_valid;
`else
    tgt_oh = free_oh;
    alloc  = svc_valid && free_valid;
`endif
    evt = svc_valid && !free_valid;

    rel = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (voice_gate[v] && fall[k] && (voice_note[v*NOTE_W +: NOTE_W] == NOTE_W'(k)))
          rel[v] = 1'b1;
      end
    end

    // Allocation wins over a release hitting the same (stolen) voice.
    gate_nxt = voice_gate;
    for (int v = 0; v < N_VOICES; v++) begin
      if (alloc && tgt_oh[v])
        gate_nxt[v] = 1'b1;
      else if (rel[v])
        gate_nxt[v] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      keys_q       <= '0;
      pend         <= '0;
      voice_gate   <= '0;
      voice_note   <= '0;
      voice_octave <= '0;
      voice_new    <= '0;
      full         <= 1'b0;
      evt_cnt      <= '0;
`ifdef PIANO_VOICE_STEAL_EN
      for (int v = 0; v < N_VOICES; v++) age[v] <= '0;
`endif
    end else begin
      keys_q     <= keys;
      pend       <= (pend & ~fall & ~svc_oh) | rise;
      voice_gate <= gate_nxt;
      full       <= &gate_nxt;
      voice_new  <= alloc ? tgt_oh : '0;
      if (evt && evt_cnt != 8'hFF)
        evt_cnt <= evt_cnt + 8'd1;
      for (int v = 0; v < N_VOICES; v++) begin
        if (alloc && tgt_oh[v]) begin
          voice_note[v*NOTE_W +: NOTE_W] <= svc_key;
          voice_octave[v*3 +: 3]         <= octave;
        end
      end
`ifdef PIANO_VOICE_STEAL_EN
      for (int v = 0; v < N_VOICES; v++) begin
        if ((alloc && tgt_oh[v]) || rel[v])
          age[v] <= '0;
        else if (alloc && voice_gate[v] && age[v] != AGE_MAX)
          age[v] <= age[v] + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_piano_voice_alloc.sv
// Directed bench for piano_voice_alloc; expected allocations are queued when keys are driven.
module tb_piano_voice_alloc;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] keys = '0;
  logic [2:0]  octave = '0;
  logic [3:0]  voice_gate;
  logic [15:0] voice_note;
  logic [11:0] voice_octave;
  logic [3:0]  voice_new;
  logic        full;
  logic [7:0]  evt_cnt;

  typedef struct {
    int voice;
    int note;
    int oct;
    int lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  piano_voice_alloc #(.N_KEYS(12), .N_VOICES(4), .NOTE_W(4), .AGE_W(3)) dut (
    .clk(clk), .resetn(resetn), .keys(keys), .octave(octave),
    .voice_gate(voice_gate), .voice_note(voice_note), .voice_octave(voice_octave),
    .voice_new(voice_new), .full(full), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int v, input int nt, input int oc, input int lat);
    exp_t e;
    e.voice = v; e.note = nt; e.oct = oc; e.lat = lat;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next voice_new pulse and checks it against the queue head.
  task automatic wait_new();
    exp_t e;
    int n;
    e = sb.pop_front();
    n = 0;
    do begin
      step(1);
      n++;
    end while (voice_new == 4'b0 && n < 8);
    chk($sformatf("new_latency_v%0d", e.voice), n, e.lat);
    chk($sformatf("new_onehot_v%0d", e.voice), voice_new, 32'(1) << e.voice);
    chk($sformatf("gate_v%0d", e.voice), voice_gate[e.voice], 1);
    chk($sformatf("note_v%0d", e.voice), voice_note[e.voice*4 +: 4], e.note);
    chk($sformatf("oct_v%0d", e.voice), voice_octave[e.voice*3 +: 3], e.oct);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gate"}, voice_gate, 0);
    chk({tag, "_note"}, voice_note, 0);
    chk({tag, "_oct"}, voice_octave, 0);
    chk({tag, "_new"}, voice_new, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_evt"}, evt_cnt, 0);
  endtask

  initial begin
    resetn = 1'b0;
    step(3);
    chk_all_zero("reset");
    resetn = 1'b1;
    step(1);

    // Single press and release
    keys[4] = 1'b1; octave = 3'd3;
    push(0, 4, 3, 2);
    wait_new();
    step(1);
    chk("single_pulse_end", voice_new, 0);
    chk("single_gate_held", voice_gate, 4'b0001);
    keys[4] = 1'b0;
    step(1);
    chk("single_release", voice_gate, 0);

    // Three keys in one cycle, serviced in ascending key order
    octave = 3'd5;
    keys[7] = 1'b1; keys[2] = 1'b1; keys[9] = 1'b1;
    push(0, 2, 5, 2); push(1, 7, 5, 1); push(2, 9, 5, 1);
    repeat (3) wait_new();
    step(1);
    chk("multi_full", full, 0);
    chk("multi_gate", voice_gate, 4'b0111);
    keys = '0;
    step(1);
    chk("multi_release", voice_gate, 0);

    // Fill the pool, then press one more key
    octave = 3'd1;
    for (int k = 0; k < 4; k++) begin
      keys[k] = 1'b1;
      push(k, k, 1, 2);
      wait_new();
    end
    step(1);
    chk("pool_full", full, 1);
    keys[5] = 1'b1;
`ifdef PIANO_VOICE_STEAL_EN
    push(0, 5, 1, 2);
    wait_new();
    step(1);
    chk("steal_evt", evt_cnt, 1);
    chk("steal_gate", voice_gate, 4'hF);
    keys[0] = 1'b0;
    step(2);
    chk("stale_release_gate", voice_gate, 4'hF);
    chk("steal_notes", voice_note, 16'h3215);
    chk("steal_evt_hold", evt_cnt, 1);
`else
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("drop_no_new", voice_new, 0);
    end
    chk("drop_notes", voice_note, 16'h3210);
    chk("drop_evt", evt_cnt, 1);
    keys[2] = 1'b0;
    step(1);
    chk("drop_release2", voice_gate, 4'b1011);
    keys[5] = 1'b0;
    step(1);
    keys[5] = 1'b1;
    push(2, 5, 1, 2);
    wait_new();
    chk("drop_evt_hold", evt_cnt, 1);
`endif
    keys = '0;
    step(2);
    chk("pool_release", voice_gate, 0);

    // Press cancelled before service
    keys[1] = 1'b1; keys[6] = 1'b1;
    step(1);
    keys[6] = 1'b0;
    push(0, 1, 1, 1);
    wait_new();
    step(3);
    chk("cancel_gate", voice_gate, 4'b0001);
    chk("cancel_no_new", voice_new, 0);
    keys = '0;
    step(1);
    chk("cancel_release", voice_gate, 0);

    // Reset mid-play with keys still held
    octave = 3'd2;
    keys[3] = 1'b1; keys[8] = 1'b1; keys[10] = 1'b1;
    push(0, 3, 2, 2); push(1, 8, 2, 1); push(2, 10, 2, 1);
    repeat (3) wait_new();
    step(1);
    chk("midplay_gate", voice_gate, 4'b0111);
    resetn = 1'b0;
    step(1);
    chk_all_zero("midreset");
    resetn = 1'b1;
    push(0, 3, 2, 2); push(1, 8, 2, 1); push(2, 10, 2, 1);
    repeat (3) wait_new();
    step(1);
    chk("realloc_gate", voice_gate, 4'b0111);
    keys = '0;
    step(1);
    chk("final_release", voice_gate, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
